btn_input_array: RTL and testbench

Parametrised N-channel button front end: synchronises, debounces and classifies raw push-button inputs into level, press, release, long-press and auto-repeat events. It replaces fixed four-button debounce wrappers. It sits between the board button pins and the clock/stopwatch control FSMs, so that time-set logic can use hold-to-scroll without its own timers.

---
 rtl/btn_pkg.sv | 19 +
 rtl/btn_channel.sv | 130 +++++++++++++
 rtl/btn_input_array.sv | 61 ++++++
 tb/tb_btn_input_array.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// Shared definitions for the button front end: hold-state encoding and
// counter sizing helper.
package btn_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PRESSED = 2'd1,
      ST_HELD    = 2'd2
   } hold_state_t;

   // Width of a counter that must hold the larger of two terminal values.
   function automatic int unsigned hold_cnt_width(input int unsigned a,
                                                  input int unsigned b);
      int unsigned m;
      m = (a > b) ? a : b;
      return $clog2(m + 1);
   endfunction

endpackage

// File: rtl/btn_channel.sv
// One button channel: 2-FF synchroniser, tick-based debounce, and the
// IDLE/PRESSED/HELD hold FSM producing press/release/long/repeat pulses.
module btn_channel
   import btn_pkg::*;
#(
   parameter int unsigned DB_SAMPLES   = 8,
   parameter int unsigned HOLD_TICKS   = 500,
   parameter int unsigned REPEAT_TICKS = 100
) (
   input  logic clk,
   input  logic rst,
   input  logic tick_i,
   input  logic btn_i,
   input  logic rpt_en_i,
   output logic level_o,
   output logic press_o,
   output logic release_o,
   output logic long_o,
   output logic repeat_o
);

   localparam int unsigned DW = $clog2(DB_SAMPLES + 1);
   localparam int unsigned HW = hold_cnt_width(HOLD_TICKS, REPEAT_TICKS);

   logic          sync1_q, sync2_q;
   logic [DW-1:0] agree_q, agree_d;
   logic          level_q, level_d;
   logic          press_q, press_d;
   logic          release_q, release_d;
   hold_state_t   state_q;
   logic [HW-1:0] hold_q;
   logic          long_q, repeat_q;

   always_comb begin
      agree_d   = agree_q;
      level_d   = level_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      if (tick_i) begin
         if (sync2_q != level_q) begin
            if (agree_q == DW'(DB_SAMPLES - 1)) begin
               level_d   = ~level_q;
               agree_d   = '0;
               press_d   = ~level_q;
               release_d = level_q;
            end else begin
               agree_d = agree_q + DW'(1);
            end
         end else begin
            agree_d = '0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q   <= 1'b0;
         sync2_q   <= 1'b0;
         agree_q   <= '0;
         level_q   <= 1'b0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
      end else begin
         sync1_q   <= btn_i;
         sync2_q   <= sync1_q;
         agree_q   <= agree_d;
         level_q   <= level_d;
         press_q   <= press_d;
         release_q <= release_d;
      end
   end

   // The press tick itself is not counted: counting begins on the next tick.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         hold_q   <= '0;
         long_q   <= 1'b0;
         repeat_q <= 1'b0;
      end else begin
         long_q   <= 1'b0;
         repeat_q <= 1'b0;
         if (release_d) begin
            state_q <= ST_IDLE;
            hold_q  <= '0;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  if (press_d) begin
                     state_q <= ST_PRESSED;
                     hold_q  <= '0;
                  end
               end
               ST_PRESSED: begin
                  if (tick_i) begin
                     if (hold_q == HW'(HOLD_TICKS - 1)) begin
                        long_q  <= 1'b1;
                        state_q <= ST_HELD;
                        hold_q  <= '0;
                     end else begin
                        hold_q <= hold_q + HW'(1);
                     end
                  end
               end
               ST_HELD: begin
                  if (tick_i) begin
                     if (hold_q == HW'(REPEAT_TICKS - 1)) begin
                        hold_q   <= '0;
                        repeat_q <= rpt_en_i;
                     end else begin
                        hold_q <= hold_q + HW'(1);
                     end
                  end
               end
               default: begin
                  state_q <= ST_IDLE;
                  hold_q  <= '0;
               end
            endcase
         end
      end
   end

   assign level_o   = level_q;
   assign press_o   = press_q;
   assign release_o = release_q;
   assign long_o    = long_q;
   assign repeat_o  = repeat_q;

endmodule

// File: rtl/btn_input_array.sv
// N-channel button front end: shared sample-tick divider feeding one
// btn_channel per button.
module btn_input_array
   import btn_pkg::*;
#(
   parameter int unsigned N_BTN        = 4,
   parameter int unsigned SAMPLE_DIV   = 100_000,
   parameter int unsigned DB_SAMPLES   = 8,
   parameter int unsigned HOLD_TICKS   = 500,
   parameter int unsigned REPEAT_TICKS = 100
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_BTN-1:0] i_btn,
   input  logic [N_BTN-1:0] i_rpt_en,
   output logic [N_BTN-1:0] o_level,
   output logic [N_BTN-1:0] o_press,
   output logic [N_BTN-1:0] o_release,
   output logic [N_BTN-1:0] o_long,
   output logic [N_BTN-1:0] o_repeat
);

   localparam int unsigned TW = $clog2(SAMPLE_DIV);

   logic [TW-1:0] div_q, div_d;
   logic          tick;

   assign tick = (div_q == TW'(SAMPLE_DIV - 1));

   always_comb begin
      div_d = tick ? '0 : div_q + TW'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_q <= '0;
      end else begin
         div_q <= div_d;
      end
   end

   for (genvar g = 0; g < N_BTN; g++) begin : g_ch
      btn_channel #(
         .DB_SAMPLES  (DB_SAMPLES),
         .HOLD_TICKS  (HOLD_TICKS),
         .REPEAT_TICKS(REPEAT_TICKS)
      ) u_ch (
         .clk      (clk),
         .rst      (rst),
         .tick_i   (tick),
         .btn_i    (i_btn[g]),
         .rpt_en_i (i_rpt_en[g]),
         .level_o  (o_level[g]),
         .press_o  (o_press[g]),
         .release_o(o_release[g]),
         .long_o   (o_long[g]),
         .repeat_o (o_repeat[g])
      );
   end

endmodule

// File: tb/tb_btn_input_array.sv
// Directed bench for btn_input_array with an event scoreboard keyed on the
// sample-tick number at which each pulse is expected.
module tb_btn_input_array;

   localparam int NB = 4;
   localparam int DIV = 4;
   localparam int DB = 3;
   localparam int HOLD = 10;
   localparam int RPT = 4;

   localparam int K_PRESS = 0;
   localparam int K_RELEASE = 1;
   localparam int K_LONG = 2;
   localparam int K_REPEAT = 3;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [NB-1:0] btn = '0;
   logic [NB-1:0] rpt_en = '0;
   logic [NB-1:0] o_level, o_press, o_release, o_long, o_repeat;

   typedef struct {
      int kind;
      int ch;
      int tick;
   } ev_t;

   ev_t  sbq[$];
   int   vec = 0;
   int   fails = 0;
   int   edge_cnt = 0;
   int   tick_num = 0;
   int   mon_idx;
   logic [4*NB-1:0] mon_pulses;

   btn_input_array #(
      .N_BTN       (NB),
      .SAMPLE_DIV  (DIV),
      .DB_SAMPLES  (DB),
      .HOLD_TICKS  (HOLD),
      .REPEAT_TICKS(RPT)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .i_btn    (btn),
      .i_rpt_en (rpt_en),
      .o_level  (o_level),
      .o_press  (o_press),
      .o_release(o_release),
      .o_long   (o_long),
      .o_repeat (o_repeat)
   );

   always #5 clk = ~clk;

   // Bench-side tick reference: every DIV-th edge after reset release.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         edge_cnt <= 0;
         tick_num <= 0;
      end else begin
         edge_cnt <= edge_cnt + 1;
         if ((edge_cnt + 1) % DIV == 0) tick_num <= tick_num + 1;
      end
   end

   function automatic string kname(input int k);
      case (k)
         K_PRESS:   return "press";
         K_RELEASE: return "release";
         K_LONG:    return "long";
         default:   return "repeat";
      endcase
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vec++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic push(input int kind, input int ch, input int tick);
      ev_t e;
      e.kind = kind;
      e.ch = ch;
      e.tick = tick;
      sbq.push_back(e);
   endtask

   task automatic next_tick();
      int t0;
      int n;
      t0 = tick_num;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (tick_num == t0 && n < 4 * DIV);
      if (tick_num == t0) check("tick_timeout", tick_num, t0 + 1);
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) next_tick();
   endtask

   // Scoreboard consumer: every pulse bit must match a pending event at its tick.
   always @(negedge clk) begin
      if (!rst) begin
         mon_pulses = {o_repeat, o_long, o_release, o_press};
         for (int k = 0; k < 4; k++) begin
            for (int c = 0; c < NB; c++) begin
               if (mon_pulses[k*NB+c]) begin
                  mon_idx = -1;
                  for (int j = 0; j < sbq.size(); j++)
                     if (mon_idx < 0 && sbq[j].kind == k && sbq[j].ch == c) mon_idx = j;
                  if (mon_idx < 0) begin
                     check($sformatf("unexpected_%s_ch%0d_tick", kname(k), c),
                           tick_num, 32'hFFFF_FFFF);
                  end else begin
                     check($sformatf("%s_ch%0d_tick", kname(k), c),
                           tick_num, sbq[mon_idx].tick);
                     sbq.delete(mon_idx);
                  end
                  if (k == K_PRESS || k == K_RELEASE)
                     check($sformatf("%s_ch%0d_level", kname(k), c),
                           o_level[c], (k == K_PRESS) ? 1 : 0);
               end
            end
         end
      end
   end

   initial begin
      int t;
      int p;
      int n;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_level", o_level, 0);
      check("rst_press", o_press, 0);
      check("rst_release", o_release, 0);
      check("rst_long", o_long, 0);
      check("rst_repeat", o_repeat, 0);
      rst = 1'b0;
      ticks(2);

      // Clean press/release on ch0, too short for long-press
      t = tick_num;
      btn[0] = 1'b1;
      push(K_PRESS, 0, t + DB);
      n = 0;
      while (!o_level[0] && n < 20) begin @(negedge clk); n++; end
      check("ch0_press_latency_ok", n <= 2 + DB * DIV + 1, 1);
      ticks(2);
      t = tick_num;
      btn[0] = 1'b0;
      push(K_RELEASE, 0, t + DB);
      n = 0;
      while (o_level[0] && n < 20) begin @(negedge clk); n++; end
      check("ch0_release_latency_ok", n <= 2 + DB * DIV + 1, 1);
      ticks(3);

      // Bounce on ch1: 1-tick and 2-tick pulses are filtered
      btn[1] = 1'b1; ticks(1); btn[1] = 1'b0; ticks(2);
      btn[1] = 1'b1; ticks(2); btn[1] = 1'b0; ticks(4);
      check("ch1_bounce_level", o_level[1], 0);
      t = tick_num;
      btn[1] = 1'b1;
      push(K_PRESS, 1, t + DB);
      push(K_RELEASE, 1, t + 2 * DB);
      ticks(DB);
      btn[1] = 1'b0;
      ticks(6);

      // Long hold on ch2 with repeat enabled; release lands on a repeat slot
      rpt_en[2] = 1'b1;
      t = tick_num;
      p = t + DB;
      btn[2] = 1'b1;
      push(K_PRESS, 2, p);
      push(K_LONG, 2, p + HOLD);
      for (int r = p + HOLD + RPT; r <= p + 30; r += RPT) push(K_REPEAT, 2, r);
      push(K_RELEASE, 2, p + 34);
      ticks(DB + 31);
      btn[2] = 1'b0;
      ticks(5);
      check("ch2_idle_level", o_level[2], 0);

      // Same hold with repeat gated off, then enabled mid-hold
      rpt_en[2] = 1'b0;
      t = tick_num;
      p = t + DB;
      btn[2] = 1'b1;
      push(K_PRESS, 2, p);
      push(K_LONG, 2, p + HOLD);
      push(K_REPEAT, 2, p + 22);
      push(K_REPEAT, 2, p + 26);
      push(K_RELEASE, 2, p + 30);
      ticks(DB + 20);
      rpt_en[2] = 1'b1;
      ticks(7);
      btn[2] = 1'b0;
      ticks(6);
      rpt_en[2] = 1'b0;

      // All channels pressed together
      t = tick_num;
      btn = '1;
      for (int c = 0; c < NB; c++) begin
         push(K_PRESS, c, t + DB);
         push(K_RELEASE, c, t + 2 * DB);
      end
      ticks(DB);
      check("all_press_vector", o_press, 4'b1111);
      check("all_level_vector", o_level, 4'b1111);
      btn = '0;
      ticks(6);

      // Reset during ch3 HELD with the pin kept pressed
      t = tick_num;
      p = t + DB;
      btn[3] = 1'b1;
      push(K_PRESS, 3, p);
      push(K_LONG, 3, p + HOLD);
      ticks(DB + 12);
      check("ch3_held_level", o_level[3], 1);
      rst = 1'b1;
      #1;
      check("midrst_level", o_level, 0);
      check("midrst_pulses", {o_press, o_release, o_long, o_repeat}, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      push(K_PRESS, 3, DB);
      push(K_LONG, 3, DB + HOLD);
      ticks(16);
      btn[3] = 1'b0;
      push(K_RELEASE, 3, 16 + DB);
      ticks(6);

      foreach (sbq[j])
         $display("pending event: %s ch%0d tick %0d", kname(sbq[j].kind), sbq[j].ch, sbq[j].tick);
      check("pending_events", sbq.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vec, fails);
      $finish;
   end

endmodule
